// File: rtl/addr_sequencer6_if.sv
// Request/decoder-drive bundle for addr_sequencer6; the optional parity pins
// exist only when ADDR_SEQ_PARITY_EN is defined.
interface addr_sequencer6_if;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_addr;
  logic [2:0] req_burst;
  logic       en;
  logic [2:0] a_hi;
  logic [2:0] a_lo;
  logic       busy;
  logic       done;
`ifdef ADDR_SEQ_PARITY_EN
  logic       req_par;
  logic       par_err;
`endif

  modport master (
    output req_valid, req_addr, req_burst,
`ifdef ADDR_SEQ_PARITY_EN
    output req_par,
    input  par_err,
`endif
    input  req_ready, en, a_hi, a_lo, busy, done
  );

  modport slave (
    input  req_valid, req_addr, req_burst,
`ifdef ADDR_SEQ_PARITY_EN
    input  req_par,
    output par_err,
`endif
    output req_ready, en, a_hi, a_lo, busy, done
  );
endinterface

// File: rtl/addr_sequencer6.sv
// Walks 1..8 consecutive 6-bit lines, pulsing en PULSE_CYCLES per line with GAP_CYCLES idle between;
// en rises 1 cycle after handshake, req_ready only in IDLE (no queueing). Option: ADDR_SEQ_PARITY_EN.
module addr_sequencer6 #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  addr_sequencer6_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [5:0] cur_addr_q, cur_addr_d;
  logic [2:0] rem_q, rem_d;
  logic       pend_q, pend_d;
  logic       en_q, en_d;
  logic [5:0] addr_out_q, addr_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic       par_err_q, par_err_d;
  logic       par_ok;

`ifdef ADDR_SEQ_PARITY_EN
  assign par_ok = ^{bus.req_burst, bus.req_addr, bus.req_par};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    pend_d     = pend_q;
    par_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          if (par_ok) begin
            state_d    = DRIVE;
            cur_addr_d = bus.req_addr;
            rem_d      = bus.req_burst;
            cnt_d      = PULSE_LOAD;
          end else begin
            par_err_d  = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // pend_q remembers whether another line follows once rem_q has been consumed
          pend_d = (rem_q != 3'd0);
          if (rem_q != 3'd0) begin
            cur_addr_d = cur_addr_q + 6'd1;
            rem_d      = rem_q - 3'd1;
          end
          if (GAP_CYCLES != 0) begin
            state_d = GAP;
            gcnt_d  = GAP_LOAD;
          end else if (rem_q != 3'd0) begin
            state_d = DRIVE;
            cnt_d   = PULSE_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt_q != 4'd0) begin
          gcnt_d = gcnt_q - 4'd1;
        end else if (pend_q) begin
          state_d = DRIVE;
          cnt_d   = PULSE_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered, aligned with state_q
    en_d       = (state_d == DRIVE);
    addr_out_d = en_d ? cur_addr_d : 6'd0;
    busy_d     = (state_d != IDLE);
    ready_d    = (state_d == IDLE);
    done_d     = en_d && (cnt_d == 4'd0) && (rem_d == 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      gcnt_q     <= 4'd0;
      cur_addr_q <= 6'd0;
      rem_q      <= 3'd0;
      pend_q     <= 1'b0;
      en_q       <= 1'b0;
      addr_out_q <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      addr_out_q <= addr_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      par_err_q  <= par_err_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.en        = en_q;
  assign bus.a_hi      = addr_out_q[5:3];
  assign bus.a_lo      = addr_out_q[2:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef ADDR_SEQ_PARITY_EN
  assign bus.par_err   = par_err_q;
`else
  logic unused_par_err;
  assign unused_par_err = par_err_q;
`endif

endmodule

// File: tb/tb_addr_sequencer6.sv
// Directed bench for addr_sequencer6: three instances (default, GAP=0, PULSE=1/GAP=2) sharing clock and reset.
module tb_addr_sequencer6;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  addr_sequencer6_if ia ();
  addr_sequencer6_if ib ();
  addr_sequencer6_if ic ();

  addr_sequencer6 u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  addr_sequencer6 #(.PULSE_CYCLES(4), .GAP_CYCLES(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  addr_sequencer6 #(.PULSE_CYCLES(1), .GAP_CYCLES(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  // {req_ready, busy, en, done, a_hi, a_lo}
  function automatic logic [9:0] st(bit r, bit b, bit e, bit d, logic [5:0] a);
    return {r, b, e, d, a};
  endfunction

  function automatic logic [9:0] obs(int which);
    case (which)
      0:       return {ia.req_ready, ia.busy, ia.en, ia.done, ia.a_hi, ia.a_lo};
      1:       return {ib.req_ready, ib.busy, ib.en, ib.done, ib.a_hi, ib.a_lo};
      default: return {ic.req_ready, ic.busy, ic.en, ic.done, ic.a_hi, ic.a_lo};
    endcase
  endfunction

  task automatic chk(string tag, int which, logic [9:0] x);
    logic [9:0] o;
    o = obs(which);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s dut%0d rdy/busy/en/done/addr observed=%b expected=%b", tag, which, o, x);
    end
  endtask

  logic [5:0] t2_addr [4];
  logic [9:0] t3_exp  [7];
  logic       t5_vld  [4];
  logic [5:0] t5_addr [4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    t2_addr = '{6'd62, 6'd63, 6'd0, 6'd1};
    t3_exp  = '{st(1'b0,1'b1,1'b1,1'b0,6'd9),  st(1'b0,1'b1,1'b0,1'b0,6'd0),
                st(1'b0,1'b1,1'b0,1'b0,6'd0),  st(1'b0,1'b1,1'b1,1'b1,6'd10),
                st(1'b0,1'b1,1'b0,1'b0,6'd0),  st(1'b0,1'b1,1'b0,1'b0,6'd0),
                st(1'b1,1'b0,1'b0,1'b0,6'd0)};
    t5_vld  = '{1'b0, 1'b1, 1'b0, 1'b1};
    t5_addr = '{6'd17, 6'd50, 6'd33, 6'd12};

    rst_n = 1'b0;
    ia.req_valid = 1'b0; ia.req_addr = 6'd0; ia.req_burst = 3'd0;
    ib.req_valid = 1'b0; ib.req_addr = 6'd0; ib.req_burst = 3'd0;
    ic.req_valid = 1'b0; ic.req_addr = 6'd0; ic.req_burst = 3'd0;
`ifdef ADDR_SEQ_PARITY_EN
    ia.req_par = 1'b0; ib.req_par = 1'b0; ic.req_par = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_a", 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));
    chk("reset_b", 1, st(1'b1,1'b0,1'b0,1'b0,6'd0));
    chk("reset_c", 2, st(1'b1,1'b0,1'b0,1'b0,6'd0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));

    // Single address 5, defaults
    ia.req_addr = 6'd5; ia.req_burst = 3'd0; ia.req_valid = 1'b1;
    @(negedge clk);
    ia.req_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("single_c%0d", c), 0, st(1'b0,1'b1,1'b1,(c == 5),6'd5));
      @(negedge clk);
    end
    chk("single_gap", 0, st(1'b0,1'b1,1'b0,1'b0,6'd0));
    @(negedge clk);
    chk("single_idle", 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));

    // Burst across the 63->0 wrap with no gap
    ib.req_addr = 6'd62; ib.req_burst = 3'd3; ib.req_valid = 1'b1;
    @(negedge clk);
    ib.req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrap_c%0d", i), 1, st(1'b0,1'b1,1'b1,(i == 15),t2_addr[i/4]));
      @(negedge clk);
    end
    chk("wrap_idle", 1, st(1'b1,1'b0,1'b0,1'b0,6'd0));

    // One-cycle pulses with two-cycle gaps
    ic.req_addr = 6'd9; ic.req_burst = 3'd1; ic.req_valid = 1'b1;
    @(negedge clk);
    ic.req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("short_c%0d", i), 2, t3_exp[i]);
      @(negedge clk);
    end

    // Asynchronous reset during the second address of an 8-line burst
    ia.req_addr = 6'd20; ia.req_burst = 3'd7; ia.req_valid = 1'b1;
    @(negedge clk);
    ia.req_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("abort_c%0d", c), 0, st(1'b0,1'b1,1'b1,1'b0,6'd20));
      @(negedge clk);
    end
    chk("abort_gap", 0, st(1'b0,1'b1,1'b0,1'b0,6'd0));
    @(negedge clk);
    chk("abort_second_addr", 0, st(1'b0,1'b1,1'b1,1'b0,6'd21));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_async", 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet%0d", c), 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));
    end
    ia.req_addr = 6'd0; ia.req_burst = 3'd0; ia.req_valid = 1'b1;
    @(negedge clk);
    ia.req_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("fresh_c%0d", c), 0, st(1'b0,1'b1,1'b1,(c == 5),6'd0));
      @(negedge clk);
    end
    chk("fresh_gap", 0, st(1'b0,1'b1,1'b0,1'b0,6'd0));
    @(negedge clk);

    // Requests while busy are ignored; one held from the gap is taken from IDLE
    ia.req_addr = 6'd3; ia.req_burst = 3'd0; ia.req_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ignore_c%0d", c), 0, st(1'b0,1'b1,1'b1,(c == 3),6'd3));
      ia.req_valid = t5_vld[c];
      ia.req_addr  = t5_addr[c];
      @(negedge clk);
    end
    chk("ignore_gap", 0, st(1'b0,1'b1,1'b0,1'b0,6'd0));
    ia.req_valid = 1'b1; ia.req_addr = 6'd40;
    @(negedge clk);
    chk("return_idle", 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));
    @(negedge clk);
    ia.req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("next_c%0d", c), 0, st(1'b0,1'b1,1'b1,(c == 3),6'd40));
      @(negedge clk);
    end
    chk("next_gap", 0, st(1'b0,1'b1,1'b0,1'b0,6'd0));
    @(negedge clk);
    chk("next_idle", 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));

`ifdef ADDR_SEQ_PARITY_EN
    ia.req_addr = 6'd0; ia.req_burst = 3'd0; ia.req_par = 1'b0; ia.req_valid = 1'b1;
    @(negedge clk);
    ia.req_valid = 1'b0;
    checks++;
    assert (ia.par_err === 1'b1) else begin
      errors++;
      $error("FAIL par_err_pulse observed=%b expected=1", ia.par_err);
    end
    chk("par_bad_idle", 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));
    @(negedge clk);
    checks++;
    assert (ia.par_err === 1'b0) else begin
      errors++;
      $error("FAIL par_err_clear observed=%b expected=0", ia.par_err);
    end
    chk("par_bad_quiet", 0, st(1'b1,1'b0,1'b0,1'b0,6'd0));
    ia.req_par = 1'b1; ia.req_valid = 1'b1;
    @(negedge clk);
    ia.req_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("par_good_c%0d", c), 0, st(1'b0,1'b1,1'b1,(c == 5),6'd0));
      @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
